// File: rtl/sparse_addr_pkg.sv
// Shared types and default widths for the sparse output-coordinate generator.
package sparse_addr_pkg;

    localparam int COORD_W_DEF = 7;
    localparam int K_W_DEF     = 3;
    localparam int MAX_LEN_DEF = 64;

    typedef logic [COORD_W_DEF-1:0] coord_t;
    typedef logic [K_W_DEF-1:0]     k_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

endpackage

// File: rtl/sparse_out_addr_gen_if.sv
// Output coordinate stream towards the accumulator-buffer write stage.
interface sparse_out_addr_gen_if #(
    parameter int COORD_W = 7,
    parameter int K_W     = 3,
    parameter int IDX_W   = 6
);
    logic               valid;
    logic               ready;
    logic [COORD_W-1:0] oh;
    logic [COORD_W-1:0] ow;
    logic [K_W-1:0]     k;
    logic [IDX_W-1:0]   idx;

    modport master (output valid, oh, ow, k, idx, input ready);
    modport slave  (input valid, oh, ow, k, idx, output ready);
endinterface

// File: rtl/out_coord_axis.sv
// Single-axis scatter check: offset by padding, stride-grid test and output-plane bound.
module out_coord_axis #(
    parameter int COORD_W = 7
) (
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] pad_i,
    input  logic [COORD_W-1:0] f_i,
    input  logic [COORD_W-1:0] bound_i,
    input  logic [1:0]         stride_log2_i,
    output logic               pass_o,
    output logic [COORD_W-1:0] coord_o
);
    localparam logic [COORD_W-1:0] ONE = 1;

    logic [COORD_W:0]   num;
    logic [COORD_W-1:0] mag;
    logic [COORD_W-1:0] mask;

    // Top bit of num is the sign of x + pad - f.
    assign num     = {1'b0, x_i} + {1'b0, pad_i} - {1'b0, f_i};
    assign mag     = num[COORD_W-1:0];
    assign mask    = (ONE << stride_log2_i) - ONE;
    assign coord_o = mag >> stride_log2_i;
    assign pass_o  = !num[COORD_W] && ((mag & mask) == '0) && (coord_o < bound_i);

endmodule

// File: rtl/sparse_out_addr_gen.sv
// Walks a compressed weight list for one activation and streams the surviving
// output coordinates; read -> capture (with bypass) -> output register.
module sparse_out_addr_gen
    import sparse_addr_pkg::*;
#(
    parameter  int COORD_W = COORD_W_DEF,
    parameter  int K_W     = K_W_DEF,
    parameter  int MAX_LEN = MAX_LEN_DEF,
    localparam int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [COORD_W-1:0]   i_h,
    input  logic [COORD_W-1:0]   i_w,
    input  logic [COORD_W-1:0]   i_pad,
    input  logic [1:0]           i_stride_log2,
    input  logic [COORD_W-1:0]   i_out_h,
    input  logic [COORD_W-1:0]   i_out_w,
    input  logic [IDX_W:0]       i_length,
    output logic                 o_w_rd_en,
    output logic [IDX_W-1:0]     o_w_addr,
    input  logic [COORD_W-1:0]   i_w_r,
    input  logic [COORD_W-1:0]   i_w_c,
    input  logic [K_W-1:0]       i_w_k,
    sparse_out_addr_gen_if.master out_if,
    output logic                 o_busy,
    output logic                 o_finish,
    output logic [IDX_W:0]       o_drop_cnt
);
    localparam logic [IDX_W:0] ONE = 1;

    typedef struct packed {
        logic [COORD_W-1:0] h;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] pad;
        logic [COORD_W-1:0] out_h;
        logic [COORD_W-1:0] out_w;
        logic [1:0]         stride_log2;
        logic [IDX_W:0]     len;
    } cfg_t;

    state_e             state_q, state_d;
    cfg_t               cfg_q, cfg_d;
    logic [IDX_W:0]     addr_q, addr_d, drop_q, drop_d;
    logic               rd_pend_q;
    logic [IDX_W-1:0]   rd_idx_q;
    logic               s1_v_q, s1_v_d;
    logic [COORD_W-1:0] s1_r_q, s1_r_d, s1_c_q, s1_c_d;
    logic [K_W-1:0]     s1_k_q, s1_k_d;
    logic [IDX_W-1:0]   s1_idx_q, s1_idx_d;
    logic               valid_q, valid_d;
    logic [COORD_W-1:0] oh_q, oh_d, ow_q, ow_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic               start_acc, s1_v, adv, rd_en, run_done, pass_h, pass_w;
    logic [COORD_W-1:0] s1_r, s1_c, coord_h, coord_w;
    logic [K_W-1:0]     s1_k;
    logic [IDX_W-1:0]   s1_idx;

    // Data returning this cycle is used directly; the register only holds it across a stall.
    assign s1_v   = rd_pend_q || s1_v_q;
    assign s1_r   = s1_v_q ? s1_r_q   : i_w_r;
    assign s1_c   = s1_v_q ? s1_c_q   : i_w_c;
    assign s1_k   = s1_v_q ? s1_k_q   : i_w_k;
    assign s1_idx = s1_v_q ? s1_idx_q : rd_idx_q;

    assign adv       = !valid_q || out_if.ready;
    assign start_acc = (state_q == IDLE) && i_start;
    assign rd_en     = (state_q == RUN) && (addr_q < cfg_q.len) && (!s1_v || adv);
    assign run_done  = (addr_q == cfg_q.len) && !s1_v && adv;

    out_coord_axis #(.COORD_W(COORD_W)) u_axis_h (
        .x_i(cfg_q.h), .pad_i(cfg_q.pad), .f_i(s1_r), .bound_i(cfg_q.out_h),
        .stride_log2_i(cfg_q.stride_log2), .pass_o(pass_h), .coord_o(coord_h)
    );

    out_coord_axis #(.COORD_W(COORD_W)) u_axis_w (
        .x_i(cfg_q.w), .pad_i(cfg_q.pad), .f_i(s1_c), .bound_i(cfg_q.out_w),
        .stride_log2_i(cfg_q.stride_log2), .pass_o(pass_w), .coord_o(coord_w)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_start) state_d = (i_length == '0) ? DONE : RUN;
            RUN:     if (run_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_d    = cfg_q;
        addr_d   = addr_q;
        drop_d   = drop_q;
        s1_r_d   = s1_r_q;
        s1_c_d   = s1_c_q;
        s1_k_d   = s1_k_q;
        s1_idx_d = s1_idx_q;
        s1_v_d   = s1_v && !adv;
        valid_d  = valid_q;
        oh_d     = oh_q;
        ow_d     = ow_q;
        k_d      = k_q;
        idx_d    = idx_q;

        if (start_acc) begin
            cfg_d  = '{h: i_h, w: i_w, pad: i_pad, out_h: i_out_h, out_w: i_out_w,
                       stride_log2: i_stride_log2, len: i_length};
            addr_d = '0;
            drop_d = '0;
        end
        if (rd_en) addr_d = addr_q + ONE;
        if (rd_pend_q) begin
            s1_r_d   = i_w_r;
            s1_c_d   = i_w_c;
            s1_k_d   = i_w_k;
            s1_idx_d = rd_idx_q;
        end
        if (adv) begin
            if (s1_v && pass_h && pass_w) begin
                valid_d = 1'b1;
                oh_d    = coord_h;
                ow_d    = coord_w;
                k_d     = s1_k;
                idx_d   = s1_idx;
            end else begin
                valid_d = 1'b0;
                if (s1_v) drop_d = drop_q + ONE;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            addr_q    <= '0;
            drop_q    <= '0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
            s1_v_q    <= 1'b0;
            s1_r_q    <= '0;
            s1_c_q    <= '0;
            s1_k_q    <= '0;
            s1_idx_q  <= '0;
            valid_q   <= 1'b0;
            oh_q      <= '0;
            ow_q      <= '0;
            k_q       <= '0;
            idx_q     <= '0;
        end else begin
            // NOTE: sequential state uses nonblocking assignments so all registers update together.
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            addr_q    <= addr_d;
            drop_q    <= drop_d;
            rd_pend_q <= rd_en;
            rd_idx_q  <= addr_q[IDX_W-1:0];
            s1_v_q    <= s1_v_d;
            s1_r_q    <= s1_r_d;
            s1_c_q    <= s1_c_d;
            s1_k_q    <= s1_k_d;
            s1_idx_q  <= s1_idx_d;
            valid_q   <= valid_d;
            oh_q      <= oh_d;
            ow_q      <= ow_d;
            k_q       <= k_d;
            idx_q     <= idx_d;
        end
    end

    assign o_w_rd_en  = rd_en;
    assign o_w_addr   = addr_q[IDX_W-1:0];
    assign o_busy     = (state_q != IDLE);
    assign o_finish   = (state_q == DONE);
    assign o_drop_cnt = drop_q;
    assign out_if.valid = valid_q;
    assign out_if.oh    = oh_q;
    assign out_if.ow    = ow_q;
    assign out_if.k     = k_q;
    assign out_if.idx   = idx_q;

endmodule
